// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_pkg                                                     |
// | Purpose  : Shared types and constants for the instruction fetch stage:  |
// |            FSM state encoding, instruction size, default reset PC.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package fetch_pkg;

  // One request in flight at most, so two states are enough.
  typedef enum logic [0:0] {
    S_REQ  = 1'b0,  // ready to issue a fetch
    S_WAIT = 1'b1   // request accepted, waiting for the response
  } state_t;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_stage_if                                                |
// | Purpose  : Bundle of fetch stage handshake/bus signals.                  |
// |   imem_req_valid/ready, imem_addr  : request channel to instr memory     |
// |   imem_rsp_valid, imem_rsp_data    : variable-latency response           |
// |   instr, instr_pc, instr_valid/ready : buffered output toward decode     |
// |   PCsrc, branch_pc, ImmOp          : branch redirect from extender       |
// |   modport master : the fetch stage;  modport slave : memory + decode     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  PCsrc;
  logic [ADDR_WIDTH-1:0] branch_pc;
  logic [DATA_WIDTH-1:0] ImmOp;

  modport master (
    output imem_req_valid, imem_addr, instr, instr_pc, instr_valid,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           PCsrc, branch_pc, ImmOp
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr, instr_pc, instr_valid,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           PCsrc, branch_pc, ImmOp
  );
endinterface
`default_nettype wire

// File: rtl/pc_next.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pc_next                                                       |
// | Purpose  : Combinational next-PC select: sequential pc+4 or the          |
// |            word-aligned branch target branch_pc + ImmOp.                 |
// |   i_pc, i_pcsrc, i_branch_pc, i_imm  -> o_next_pc                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pc_next
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  wire logic [ADDR_WIDTH-1:0] i_pc,
  input  wire logic                  i_pcsrc,
  input  wire logic [ADDR_WIDTH-1:0] i_branch_pc,
  input  wire logic [DATA_WIDTH-1:0] i_imm,
  output logic      [ADDR_WIDTH-1:0] o_next_pc
);

  localparam logic [ADDR_WIDTH-1:0] c_step       = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~ADDR_WIDTH'(INSTR_BYTES - 1);

  logic [ADDR_WIDTH-1:0] w_imm_ext;
  logic [ADDR_WIDTH-1:0] w_target;

  // Fit the immediate to address width: truncate if wider, sign-extend if narrower.
  generate
    if (DATA_WIDTH >= ADDR_WIDTH) begin : g_imm_trunc
      assign w_imm_ext = i_imm[ADDR_WIDTH-1:0];
    end else begin : g_imm_sext
      assign w_imm_ext = {{(ADDR_WIDTH-DATA_WIDTH){i_imm[DATA_WIDTH-1]}}, i_imm};
    end
  endgenerate

  // Wraps modulo 2^ADDR_WIDTH; low bits forced to zero so fetches stay aligned.
  assign w_target  = (i_branch_pc + w_imm_ext) & c_align_mask;
  assign o_next_pc = i_pcsrc ? w_target : (i_pc + c_step);

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_stage                                                   |
// | Purpose  : Instruction fetch: holds the PC, issues one word request at a |
// |            time, buffers one instruction toward decode, and applies      |
// |            branch redirects, squashing a fetch already in flight.        |
// |   clk, rst : clock, synchronous active-high reset                        |
// |   bus      : fetch_stage_if.master (memory request/response, decode      |
// |              output buffer, redirect inputs)                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input wire logic     clk,
  input wire logic     rst,
  fetch_stage_if.master bus
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0] r_instr_pc;
  logic                  r_instr_valid;
  logic                  r_squash;   // response of the in-flight request is stale

  logic                  w_req_valid;
  logic                  w_handshake;
  logic [ADDR_WIDTH-1:0] w_next_pc;

  // Only request when the buffer will be free by the time data returns.
  assign w_req_valid = !rst && (r_state == S_REQ) && (!r_instr_valid || bus.instr_ready);
  assign w_handshake = w_req_valid && bus.imem_req_ready;

  pc_next #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pc_next (
    .i_pc        (r_pc),
    .i_pcsrc     (bus.PCsrc),
    .i_branch_pc (bus.branch_pc),
    .i_imm       (bus.ImmOp),
    .o_next_pc   (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_squash      <= 1'b0;
    end else if (bus.PCsrc) begin
      // Redirect wins over load and increment; the buffer is flushed.
      r_pc          <= w_next_pc;
      r_instr_valid <= 1'b0;
      case (r_state)
        S_REQ: begin
          if (w_handshake) begin
            // Old pc went out this cycle; its data must be dropped.
            r_state  <= S_WAIT;
            r_squash <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            r_state  <= S_REQ;
            r_squash <= 1'b0;
          end else begin
            r_squash <= 1'b1;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end else begin
      if (r_instr_valid && bus.instr_ready) begin
        r_instr_valid <= 1'b0;
      end
      case (r_state)
        S_REQ: begin
          if (w_handshake) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            r_state <= S_REQ;
            if (r_squash) begin
              r_squash <= 1'b0;
            end else begin
              // Overrides the consume-clear above when both happen.
              r_instr       <= bus.imem_rsp_data;
              r_instr_pc    <= r_pc;
              r_instr_valid <= 1'b1;
              r_pc          <= w_next_pc;
            end
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_addr      = r_pc;
  assign bus.instr          = r_instr;
  assign bus.instr_pc       = r_instr_pc;
  assign bus.instr_valid    = r_instr_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_stage                                                |
// | Purpose  : Self-checking bench for fetch_stage: directed scenarios with  |
// |            literal expectations, then randomized traffic against a       |
// |            transaction-level model (outstanding request, stale flag,     |
// |            one-entry buffer). A second instance checks PC wrap.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();
  fetch_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();

  fetch_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  fetch_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Wrap instance: always-ready memory with one-cycle latency, always-ready decode.
  logic r2v;
  always @(posedge clk) r2v <= !rst && bus2.imem_req_valid && bus2.imem_req_ready;
  assign bus2.imem_req_ready = 1'b1;
  assign bus2.imem_rsp_valid = r2v;
  assign bus2.imem_rsp_data  = 32'h0000_0013;
  assign bus2.instr_ready    = 1'b1;
  assign bus2.PCsrc          = 1'b0;
  assign bus2.branch_pc      = 32'h0;
  assign bus2.ImmOp          = 32'h0;

  int n_vec = 0;
  int n_err = 0;

  // Stimulus for the next cycle.
  logic        d_rst, d_req_ready, d_instr_ready, d_pcsrc;
  logic [31:0] d_bpc, d_imm;
  int          d_lat;

  // Memory responder for the main instance.
  logic        mem_busy = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = '0;

  // Reference model: transaction-level view of the fetch stage.
  logic [31:0] m_pc = '0, m_issue = '0, m_bi = '0, m_bp = '0;
  logic        m_out = 1'b0, m_stale = 1'b0, m_bv = 1'b0;

  logic [31:0] q2[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    logic        rsp, exp_rv, hs, hs_dut;
    logic [31:0] tgt;
    @(negedge clk);
    rsp = mem_busy && (mem_wait == 0);
    if (mem_busy && mem_wait != 0) mem_wait--;
    rst                 = d_rst;
    bus1.imem_rsp_valid = rsp;
    bus1.imem_rsp_data  = rsp ? mem_word(mem_addr) : $urandom;
    bus1.imem_req_ready = d_req_ready;
    bus1.instr_ready    = d_instr_ready;
    bus1.PCsrc          = d_pcsrc;
    bus1.branch_pc      = d_bpc;
    bus1.ImmOp          = d_imm;
    #1;
    exp_rv = !d_rst && !m_out && (!m_bv || d_instr_ready);
    chk("req_valid", {31'b0, bus1.imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) chk("req_addr", bus1.imem_addr, m_pc);
    if (!d_rst) begin
      chk("instr_valid", {31'b0, bus1.instr_valid}, {31'b0, m_bv});
      if (m_bv) begin
        chk("instr", bus1.instr, m_bi);
        chk("instr_pc", bus1.instr_pc, m_bp);
      end
    end
    if (bus2.imem_req_valid === 1'b1) q2.push_back(bus2.imem_addr);

    // Memory reacts to what the DUT actually does.
    hs_dut = (bus1.imem_req_valid === 1'b1) && d_req_ready;
    if (d_rst) begin
      mem_busy = 1'b0;
    end else begin
      if (rsp) mem_busy = 1'b0;
      if (hs_dut) begin
        mem_busy = 1'b1;
        mem_addr = bus1.imem_addr;
        mem_wait = d_lat - 1;
      end
    end

    // Model update for the coming edge.
    hs = exp_rv && d_req_ready;
    if (d_rst) begin
      m_pc = 32'h0; m_out = 1'b0; m_stale = 1'b0; m_bv = 1'b0;
    end else if (d_pcsrc) begin
      tgt = (d_bpc + d_imm) & 32'hFFFF_FFFC;
      if (m_out && rsp) begin
        m_out = 1'b0; m_stale = 1'b0;
      end else if (m_out || hs) begin
        if (hs) m_issue = m_pc;
        m_out = 1'b1; m_stale = 1'b1;
      end
      m_pc = tgt;
      m_bv = 1'b0;
    end else begin
      if (m_bv && d_instr_ready) m_bv = 1'b0;
      if (hs) begin
        m_out = 1'b1; m_stale = 1'b0; m_issue = m_pc;
      end else if (m_out && rsp) begin
        m_out = 1'b0;
        if (m_stale) begin
          m_stale = 1'b0;
        end else begin
          m_bv = 1'b1; m_bi = mem_word(m_issue); m_bp = m_issue;
          m_pc = m_issue + 32'd4;
        end
      end
    end
  endtask

  task automatic go(input logic rr, input logic ir, input logic pcs,
                    input logic [31:0] bpc, input logic [31:0] imm, input int lat);
    d_rst = 1'b0; d_req_ready = rr; d_instr_ready = ir; d_pcsrc = pcs;
    d_bpc = bpc; d_imm = imm; d_lat = lat;
    step();
  endtask

  task automatic idle();
    go(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1);
  endtask

  initial begin
    logic [31:0] tmp;
    int p_rr, p_ir, p_pcs, lat_max;

    d_rst = 1'b1; d_req_ready = 1'b1; d_instr_ready = 1'b1; d_pcsrc = 1'b0;
    d_bpc = '0; d_imm = '0; d_lat = 1;
    step(); step();
    q2.delete();

    // Streaming with an always-ready 1-cycle memory.
    idle();                                                   // s0
    chk("rst_req_valid", {31'b0, bus1.imem_req_valid}, 32'd1);
    chk("rst_addr", bus1.imem_addr, 32'h0);
    chk("rst_instr_valid", {31'b0, bus1.instr_valid}, 32'd0);
    chk("rst_instr", bus1.instr, 32'h0);
    chk("rst_instr_pc", bus1.instr_pc, 32'h0);
    idle();                                                   // s1
    idle();                                                   // s2
    chk("first_valid", {31'b0, bus1.instr_valid}, 32'd1);
    chk("first_pc", bus1.instr_pc, 32'h0);
    chk("addr_4", bus1.imem_addr, 32'h4);
    idle(); idle();                                           // s3, s4
    chk("addr_8", bus1.imem_addr, 32'h8);
    idle();                                                   // s5

    // Decode stalls five cycles with pc 0x8 buffered.
    for (int i = 0; i < 5; i++) begin                         // s6..s10
      go(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1);
      chk("stall_no_req", {31'b0, bus1.imem_req_valid}, 32'd0);
      chk("stall_pc", bus1.instr_pc, 32'h8);
      chk("stall_instr", bus1.instr, mem_word(32'h8));
    end
    go(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 2);                    // s11
    chk("resume_addr", bus1.imem_addr, 32'hC);

    // Redirect while waiting: 0x10 + (-8) = 0x8, in-flight data squashed.
    go(1'b1, 1'b1, 1'b1, 32'h10, 32'hFFFF_FFF8, 1);           // s12
    idle();                                                   // s13
    chk("squash_flush", {31'b0, bus1.instr_valid}, 32'd0);
    idle();                                                   // s14
    chk("redir_addr_8", bus1.imem_addr, 32'h8);

    // Redirect coincident with the response: 0x20 + 0x40.
    go(1'b1, 1'b1, 1'b1, 32'h20, 32'h40, 1);                  // s15
    idle();                                                   // s16
    chk("redir_addr_60", bus1.imem_addr, 32'h60);
    idle();                                                   // s17
    go(1'b0, 1'b1, 1'b1, 32'h0, 32'h4, 1);                    // s18
    chk("no_squash_pc", bus1.instr_pc, 32'h60);

    // Redirect coincident with the handshake at 0x4.
    go(1'b1, 1'b1, 1'b1, 32'h100, 32'h4, 1);                  // s19
    chk("hs_addr_4", bus1.imem_addr, 32'h4);
    idle();                                                   // s20
    idle();                                                   // s21
    chk("hs_target", bus1.imem_addr, 32'h104);
    idle();                                                   // s22
    go(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 3);                    // s23
    chk("target_pc", bus1.instr_pc, 32'h104);

    // Reset while waiting for a response.
    d_rst = 1'b1; step();                                     // s24
    idle();                                                   // s25
    chk("wait_rst_addr", bus1.imem_addr, 32'h0);
    chk("wait_rst_valid", {31'b0, bus1.instr_valid}, 32'd0);

    // Wrap instance: FFFFFFFC then 0.
    chk("wrap_count", {31'b0, q2.size() >= 2}, 32'd1);
    if (q2.size() >= 2) begin
      tmp = q2[0]; chk("wrap_first", tmp, 32'hFFFF_FFFC);
      tmp = q2[1]; chk("wrap_second", tmp, 32'h0);
    end

    // Randomized traffic.
    for (int blk = 0; blk < 10; blk++) begin
      p_rr    = $urandom_range(30, 100);
      p_ir    = $urandom_range(20, 100);
      p_pcs   = $urandom_range(0, 15);
      lat_max = $urandom_range(1, 4);
      for (int c = 0; c < 400; c++) begin
        d_rst         = ($urandom_range(0, 299) == 0);
        d_req_ready   = ($urandom_range(1, 100) <= p_rr);
        d_instr_ready = ($urandom_range(1, 100) <= p_ir);
        d_pcsrc       = ($urandom_range(1, 100) <= p_pcs);
        d_bpc         = $urandom;
        d_imm         = ($urandom_range(0, 1) == 1) ? $urandom
                                                    : 32'($urandom_range(0, 511)) - 32'd256;
        d_lat         = $urandom_range(1, lat_max);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the immediate extender and decoder.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel with variable-latency response.
- Buffers one fetched instruction and its PC toward decode.
- Takes the branch redirect (PCsrc plus sign-extended ImmOp from the extender) and squashes stale fetches.

Parameters:
- DATA_WIDTH, 32, instruction / immediate width.
- ADDR_WIDTH, 32, PC and memory address width.
- RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  ADDR_WIDTH  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid; always accepted.
- imem_rsp_data  in  DATA_WIDTH  fetched instruction.
- instr  out  DATA_WIDTH  buffered instruction to extender/decoder.
- instr_pc  out  ADDR_WIDTH  PC of instr.
- instr_valid  out  1  output buffer holds an instruction.
- instr_ready  in  1  downstream consumes instr this cycle.
- PCsrc  in  1  redirect: take branch/jump this cycle.
- branch_pc  in  ADDR_WIDTH  PC of the redirecting instruction.
- ImmOp  in  DATA_WIDTH  sign-extended immediate from the extender.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=S_REQ, instr_valid=0, instr=0, instr_pc=0, squash=0.
  - imem_req_valid=0 during the reset cycle.
  - imem_rsp_valid is ignored in the reset cycle.
  - Memory shares rst and drops outstanding requests, so no pre-reset response appears after reset.
- Single outstanding request maximum.
- FSM:
  - S_REQ:
    - imem_req_valid = !instr_valid || instr_ready. This guarantees the buffer is empty when the response lands.
    - imem_addr = pc.
    - On handshake (valid && ready): go to S_WAIT.
  - S_WAIT:
    - imem_req_valid=0.
    - On imem_rsp_valid with squash=0: instr<=data, instr_pc<=pc, instr_valid<=1, pc<=pc+4, go to S_REQ.
    - On imem_rsp_valid with squash=1: discard data, squash<=0, go to S_REQ (pc already redirected).
- Output buffer: instr_valid clears when instr_valid && instr_ready, unless it is reloaded in the same cycle. A response landing in a consume cycle loads the buffer and leaves instr_valid=1.
- Request latency: earliest response one cycle after the request handshake. Best-case throughput is 1 instruction per 2 cycles.
- Redirect (PCsrc=1):
  - Target = branch_pc + ImmOp, truncated to ADDR_WIDTH. Bits [1:0] are forced to 0.
  - pc<=target and instr_valid<=0 (flush), regardless of instr_ready.
  - In S_WAIT with no response this cycle: squash<=1.
  - In S_WAIT with a response this cycle: the response is discarded, go to S_REQ, squash stays 0.
  - In S_REQ with a handshake this cycle (old pc issued): squash<=1, go to S_WAIT.
  - In S_REQ with no handshake: stay in S_REQ; the next request uses the target.
  - Redirect has priority over response load and pc+4 increment.
- Arithmetic: all PC math is modulo 2^ADDR_WIDTH. 32'hFFFF_FFFC+4 = 32'h0000_0000; no flag is raised.
- imem_addr, instr and instr_pc stay stable while their valid is high and not yet accepted.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {S_REQ, S_WAIT}.
  - INSTR_BYTES=4.
  - default RESET_PC.
- One sub-module, pc_next: combinational next-PC select (pc+4 vs. aligned branch target). This keeps the FSM file register-only.

Test Plan:
- Reset, then memory always ready with 1-cycle latency and instr_ready=1 → requests at 0x0, 0x4, 0x8; instr_pc matches; first instr_valid 2 cycles after reset release.
- instr_ready=0 for 5 cycles while instr_valid=1 → no imem_req_valid; instr/instr_pc held; fetch resumes the cycle instr_ready rises.
- PCsrc=1 with branch_pc=0x10, ImmOp=0xFFFF_FFF8 while in S_WAIT → old response discarded; next request addr 0x8; buffer flushed.
- PCsrc coincident with imem_rsp_valid, branch_pc=0x20, ImmOp=0x40 → data discarded, next request 0x60, no squash carried.
- PCsrc coincident with request handshake at addr 0x4 → that response discarded; following request at target.
- RESET_PC=32'hFFFF_FFFC → second request addr 0x0 (wrap). Assert rst while in S_WAIT → returns to S_REQ, instr_valid=0, first request at RESET_PC.
